// File: rtl/dmem_access_unit.sv
// Memory-stage load/store sequencer: lane mask/data forming, req/ready + valid handshake, pipeline stall.
// Optional `DMEM_TIMEOUT_EN adds a REQ/WAIT watchdog that aborts after MAX_WAIT cycles and pulses o_bus_err.
module dmem_access_unit #(
  parameter int MAX_WAIT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_en,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_valid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_done,
  output logic        o_load_valid,
  output logic [31:0] o_load_rdata,
  output logic [2:0]  o_load_funct3,
  output logic [1:0]  o_load_byte_offset,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  // Handshake: o_dmem_req stays high with addr/we/mask/wdata frozen until a cycle
  // with i_dmem_ready; read data is taken only on i_dmem_valid in that cycle or in WAIT.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_mask;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_misaligned;

  logic        w_misaligned, w_accept, w_capture, w_abort, w_timeout;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;

  always_comb begin
    w_misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misaligned = i_addr[0];
      2'b10:   w_misaligned = (i_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_accept = i_rst_n & (r_state == S_IDLE) & i_mem_en & ~w_misaligned;

  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        w_mask  = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        w_mask  = 4'b0011 << i_addr[1:0];
        w_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
    if (!i_is_store) w_mask = 4'b1111;
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  logic [CW-1:0] r_wait_cnt;
  logic          r_bus_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_accept) r_wait_cnt <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_wait_cnt == CW'(MAX_WAIT - 1));
  assign o_bus_err = r_bus_err;
`else
  // MAX_WAIT is only meaningful with the watchdog; this compare is constant false.
  assign w_timeout = (MAX_WAIT < 0);
  assign o_bus_err = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_REQ;
      S_REQ: begin
        if (i_dmem_ready) begin
          if (r_we) w_next = S_RESP;
          else if (i_dmem_valid) begin
            w_next    = S_RESP;
            w_capture = 1'b1;
          end else w_next = S_WAIT;
        end else if (w_timeout) w_abort = 1'b1;
      end
      S_WAIT: begin
        if (i_dmem_valid) begin
          w_next    = S_RESP;
          w_capture = 1'b1;
        end else if (w_timeout) w_abort = 1'b1;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_misaligned <= (r_state == S_IDLE) & i_mem_en & w_misaligned;
      if (w_accept) begin
        r_addr   <= {i_addr[31:2], 2'b00};
        r_wdata  <= w_wdata;
        r_mask   <= w_mask;
        r_we     <= i_is_store;
        r_funct3 <= i_funct3;
        r_off    <= i_addr[1:0];
      end
      if (w_capture) r_rdata <= i_dmem_rdata;
    end
  end

  assign o_stall            = w_accept | (r_state == S_REQ) | (r_state == S_WAIT);
  assign o_dmem_req         = (r_state == S_REQ);
  assign o_dmem_we          = r_we;
  assign o_dmem_addr        = r_addr;
  assign o_dmem_mask        = r_mask;
  assign o_dmem_wdata       = r_wdata;
  assign o_done             = (r_state == S_RESP);
  assign o_load_valid       = (r_state == S_RESP) & ~r_we;
  assign o_load_rdata       = r_rdata;
  assign o_load_funct3      = r_funct3;
  assign o_load_byte_offset = r_off;
  assign o_misaligned       = r_misaligned;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, random ops vs. a byte-level reference model,
// reset-during-WAIT and (with DMEM_TIMEOUT_EN) watchdog sequences.
module tb_dmem_access_unit;

  localparam int TB_MAX_WAIT = 8;

  logic        clk, rst_n;
  logic        i_mem_en, i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_store_data;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready, i_dmem_valid;
  logic [31:0] i_dmem_rdata;
  logic        o_done, o_load_valid;
  logic [31:0] o_load_rdata;
  logic [2:0]  o_load_funct3;
  logic [1:0]  o_load_byte_offset;
  logic        o_misaligned, o_bus_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  dmem_access_unit #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_en(i_mem_en), .i_is_store(i_is_store), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_store_data(i_store_data),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready), .i_dmem_valid(i_dmem_valid), .i_dmem_rdata(i_dmem_rdata),
    .o_done(o_done), .o_load_valid(o_load_valid), .o_load_rdata(o_load_rdata),
    .o_load_funct3(o_load_funct3), .o_load_byte_offset(o_load_byte_offset),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          rd;
    int          wn;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        mis;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: access size in bytes drives alignment, lane mask and replication
  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int m;
    if (!st) return 4'hF;
    sz = 1 << f3[1:0];
    m  = ((1 << sz) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  task automatic drive_idle();
    i_mem_en = 1'b0; i_is_store = 1'b0; i_funct3 = 3'b000; i_addr = '0; i_store_data = '0;
    i_dmem_ready = 1'b0; i_dmem_valid = 1'b0; i_dmem_rdata = '0;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the following IDLE cycle.
  task automatic do_op(input vec_t v);
    int  done_c;
    logic junk_ok;
    if (v.mis) begin
      for (int c = 0; c <= 2; c++) begin
        i_mem_en = (c == 0); i_is_store = v.st; i_funct3 = v.f3; i_addr = v.addr; i_store_data = v.data;
        i_dmem_ready = 1'b0; i_dmem_valid = 1'b0;
        @(negedge clk);
        chk("mis_stall", 32'(o_stall), 32'(1'b0));
        chk("mis_req", 32'(o_dmem_req), 32'(1'b0));
        chk("mis_pulse", 32'(o_misaligned), 32'(c == 1));
        chk("mis_done", 32'(o_done), 32'(1'b0));
        @(posedge clk); #1;
      end
      i_mem_en = 1'b0;
      return;
    end
    if (!v.st) exp_q.push_back(v.rdata);
    done_c = 2 + v.rd + (v.st ? 0 : v.wn);
    for (int c = 0; c <= done_c; c++) begin
      i_mem_en = 1'b1; i_is_store = v.st; i_funct3 = v.f3; i_addr = v.addr; i_store_data = v.data;
      i_dmem_ready = (c == 1 + v.rd);
      junk_ok = (c < 1 + v.rd) || (c == done_c) || v.st;
      if (!v.st && c == 1 + v.rd + v.wn) begin
        i_dmem_valid = 1'b1; i_dmem_rdata = v.rdata;
      end else begin
        i_dmem_valid = junk_ok ? 1'($urandom_range(0, 1)) : 1'b0;
        i_dmem_rdata = $urandom;
      end
      @(negedge clk);
      chk("stall", 32'(o_stall), 32'(c < done_c));
      chk("req", 32'(o_dmem_req), 32'(c >= 1 && c <= 1 + v.rd));
      chk("done", 32'(o_done), 32'(c == done_c));
      chk("load_valid", 32'(o_load_valid), 32'(c == done_c && !v.st));
      chk("misaligned", 32'(o_misaligned), 32'(1'b0));
      chk("bus_err", 32'(o_bus_err), 32'(1'b0));
      if (c >= 1 && c <= 1 + v.rd) begin
        chk("addr", o_dmem_addr, {v.addr[31:2], 2'b00});
        chk("mask", 32'(o_dmem_mask), 32'(v.mask));
        chk("we", 32'(o_dmem_we), 32'(v.st));
        if (v.st) chk("wdata", o_dmem_wdata, v.wdata);
      end
      if (c == done_c && !v.st) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'(1), 32'(0));
        else chk("load_rdata", o_load_rdata, exp_q.pop_front());
        chk("load_funct3", 32'(o_load_funct3), 32'(v.f3));
        chk("load_off", 32'(o_load_byte_offset), 32'(v.addr[1:0]));
      end
      @(posedge clk); #1;
    end
    i_mem_en = 1'b0; i_dmem_ready = 1'b0; i_dmem_valid = 1'b0;
  endtask

  task automatic run_random(input int n);
    logic [2:0] f3_l[5];
    vec_t v;
    f3_l = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int k = 0; k < n; k++) begin
      v.st    = 1'($urandom_range(0, 1));
      v.f3    = v.st ? 3'($urandom_range(0, 2)) : f3_l[$urandom_range(0, 4)];
      v.addr  = $urandom;
      v.data  = $urandom;
      v.rd    = $urandom_range(0, 3);
      v.wn    = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.mis   = m_mis(v.f3, v.addr);
      v.mask  = m_mask(v.st, v.f3, v.addr);
      v.wdata = m_wdata(v.f3, v.data);
      do_op(v);
    end
  endtask

  task automatic reset_in_wait();
    i_mem_en = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
    @(posedge clk); #1;
    i_dmem_ready = 1'b1; i_dmem_valid = 1'b0;
    @(posedge clk); #1;
    i_dmem_ready = 1'b0;
    @(negedge clk);
    chk("rw_stall_wait", 32'(o_stall), 32'(1'b1));
    chk("rw_rdata_before", 32'(o_load_rdata != 32'h0), 32'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("rw_req", 32'(o_dmem_req), 32'(1'b0));
    chk("rw_stall", 32'(o_stall), 32'(1'b0));
    chk("rw_rdata", o_load_rdata, 32'h0);
    chk("rw_mask", 32'(o_dmem_mask), 32'(4'h0));
    i_mem_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      i_dmem_valid = 1'b1; i_dmem_rdata = $urandom;
      @(negedge clk);
      chk("rw_late_done", 32'(o_done), 32'(1'b0));
      chk("rw_late_lv", 32'(o_load_valid), 32'(1'b0));
      chk("rw_late_rdata", o_load_rdata, 32'h0);
    end
    @(posedge clk); #1;
    i_dmem_valid = 1'b0;
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic timeout_seq();
    i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h400;
    for (int c = 0; c <= 13; c++) begin
      i_mem_en = (c == 0); i_dmem_ready = 1'b0; i_dmem_valid = (c == 10); i_dmem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      chk("to_req", 32'(o_dmem_req), 32'(c >= 1 && c <= TB_MAX_WAIT));
      chk("to_stall", 32'(o_stall), 32'(c <= TB_MAX_WAIT));
      chk("to_bus_err", 32'(o_bus_err), 32'(c == TB_MAX_WAIT + 1));
      chk("to_done", 32'(o_done), 32'(1'b0));
      @(posedge clk); #1;
    end
    i_dmem_valid = 1'b0;
  endtask
`endif

  initial begin
    drive_idle();
    rst_n = 1'b0;
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,      0, 0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h203, 32'h0,      0, 4, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 3'b001, 32'h12,  32'h0000ABCD, 0, 0, 32'h0,      4'hC, 32'hABCDABCD, 1'b0};
    vecs[3]  = '{1'b0, 3'b010, 32'h102, 32'h0,      0, 0, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[4]  = '{1'b1, 3'b000, 32'h7,   32'h0000005A, 1, 0, 32'h0,      4'h8, 32'h5A5A5A5A, 1'b0};
    vecs[5]  = '{1'b1, 3'b010, 32'h20,  32'h12345678, 2, 0, 32'h0,      4'hF, 32'h12345678, 1'b0};
    vecs[6]  = '{1'b0, 3'b001, 32'h41,  32'h0,      0, 0, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 3'b101, 32'h46,  32'h0,      1, 2, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 3'b001, 32'h13,  32'h0,      0, 0, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 3'b100, 32'h3,   32'h0,      3, 1, 32'h80808080, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 3'b000, 32'h0,   32'hFFFFFFAB, 0, 0, 32'h0,      4'h1, 32'hABABABAB, 1'b0};
    vecs[11] = '{1'b0, 3'b010, 32'hFFC, 32'h0,      0, 0, 32'h76543210, 4'hF, 32'h0,        1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(o_stall), 32'(1'b0));
    chk("rst_req", 32'(o_dmem_req), 32'(1'b0));
    chk("rst_we", 32'(o_dmem_we), 32'(1'b0));
    chk("rst_addr", o_dmem_addr, 32'h0);
    chk("rst_mask", 32'(o_dmem_mask), 32'(4'h0));
    chk("rst_wdata", o_dmem_wdata, 32'h0);
    chk("rst_done", 32'(o_done), 32'(1'b0));
    chk("rst_lv", 32'(o_load_valid), 32'(1'b0));
    chk("rst_rdata", o_load_rdata, 32'h0);
    chk("rst_f3", 32'(o_load_funct3), 32'(3'b000));
    chk("rst_off", 32'(o_load_byte_offset), 32'(2'b00));
    chk("rst_mis", 32'(o_misaligned), 32'(1'b0));
    chk("rst_buserr", 32'(o_bus_err), 32'(1'b0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) do_op(vecs[i]);
    run_random(40);
    reset_in_wait();
    run_random(10);
`ifdef DMEM_TIMEOUT_EN
    timeout_seq();
    run_random(5);
`endif
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
